// File: rtl/kbd_cmd_seq.sv
// rtl/kbd_cmd_seq.sv - keyboard bring-up/LED command sequencer with scan-code queue
// Optional KBD_SCAN_FIFO_EN: FIFO_DEPTH-entry scan queue instead of a single holding register.
module kbd_cmd_seq #(
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int MAX_RETRY      = 3,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] ps2_tx_data,
   output logic       ps2_write,
   input  logic [7:0] ps2_rx_data,
   input  logic       ps2_read,
   input  logic       ps2_busy,
   input  logic       ps2_err,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       led_ack,
   output logic       kbd_int,
   input  logic       kbd_int_ack,
   output logic [7:0] kbd_data,
   output logic       ready,
   output logic       init_err,
   output logic       overflow
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {S_INIT, S_TX, S_WACK, S_WBAT, S_RUN, S_FAIL} state_t;
   typedef enum logic [1:0] {ST_RESET, ST_ENABLE, ST_LEDCMD, ST_LEDARG} step_t;

   state_t          state, state_nxt;
   step_t           step, step_nxt;
   logic [7:0]      cmd, cmd_nxt;
   logic [RW-1:0]   retry, retry_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [2:0]      led_latch, led_latch_nxt;
   logic            write_nxt, led_ack_nxt;
   logic            resend, push, push_ok, pop, timed_out;
   logic [CW-1:0]   q_count;
   logic            q_full;

   assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nxt     = state;
      step_nxt      = step;
      cmd_nxt       = cmd;
      retry_nxt     = retry;
      timer_nxt     = timer;
      led_latch_nxt = led_latch;
      write_nxt     = 1'b0;
      led_ack_nxt   = 1'b0;
      resend        = 1'b0;
      push          = 1'b0;
      case (state)
         S_INIT: begin
            cmd_nxt   = 8'hFF;
            step_nxt  = ST_RESET;
            retry_nxt = '0;
            state_nxt = S_TX;
         end
         S_TX: begin
            if (!ps2_busy) begin
               write_nxt = 1'b1;
               timer_nxt = '0;
               state_nxt = S_WACK;
            end
         end
         S_WACK: begin
            timer_nxt = timer + 1'b1;
            if (ps2_err) begin
               resend = 1'b1;
            end else if (ps2_read) begin
               if (ps2_rx_data == 8'hFA) begin
                  retry_nxt = '0;
                  case (step)
                     ST_RESET: begin
                        timer_nxt = '0;
                        state_nxt = S_WBAT;
                     end
                     ST_ENABLE: state_nxt = S_RUN;
                     ST_LEDCMD: begin
                        cmd_nxt   = {5'b0, led_latch};
                        step_nxt  = ST_LEDARG;
                        state_nxt = S_TX;
                     end
                     default: begin
                        led_ack_nxt = 1'b1;
                        state_nxt   = S_RUN;
                     end
                  endcase
               end else if (ps2_rx_data == 8'hFE) begin
                  resend = 1'b1;
               end else begin
                  // stray bytes only count as keystrokes once the keyboard is up
                  push = (step == ST_LEDCMD) || (step == ST_LEDARG);
               end
            end else if (timed_out) begin
               resend = 1'b1;
            end
         end
         S_WBAT: begin
            timer_nxt = timer + 1'b1;
            if (ps2_read && ps2_rx_data == 8'hAA) begin
               retry_nxt = '0;
               cmd_nxt   = 8'hF4;
               step_nxt  = ST_ENABLE;
               state_nxt = S_TX;
            end else if ((ps2_read && ps2_rx_data == 8'hFC) || timed_out) begin
               resend = 1'b1;
            end
         end
         S_RUN: begin
            push = ps2_read;
            if (led_req && !led_ack) begin
               led_latch_nxt = led_val;
               cmd_nxt       = 8'hED;
               step_nxt      = ST_LEDCMD;
               state_nxt     = S_TX;
            end
         end
         default: ;
      endcase
      // a failed BAT re-sends 0xFF, which is still held in cmd
      if (resend) begin
         if (retry == RW'(MAX_RETRY)) begin
            state_nxt = S_FAIL;
         end else begin
            retry_nxt = retry + 1'b1;
            state_nxt = S_TX;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_INIT;
         step        <= ST_RESET;
         cmd         <= 8'h00;
         retry       <= '0;
         timer       <= '0;
         led_latch   <= 3'b000;
         ps2_write   <= 1'b0;
         ps2_tx_data <= 8'h00;
         led_ack     <= 1'b0;
      end else begin
         state     <= state_nxt;
         step      <= step_nxt;
         cmd       <= cmd_nxt;
         retry     <= retry_nxt;
         timer     <= timer_nxt;
         led_latch <= led_latch_nxt;
         ps2_write <= write_nxt;
         led_ack   <= led_ack_nxt;
         if (write_nxt) begin
            ps2_tx_data <= cmd;
         end
      end
   end

   assign ready    = (state == S_RUN);
   assign init_err = (state == S_FAIL);
   assign kbd_int  = (q_count != '0);
   assign pop      = kbd_int && kbd_int_ack && (state != S_FAIL);
   assign push_ok  = push && (!q_full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_count  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef KBD_SCAN_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= ps2_rx_data;
      end
   end

   assign q_full   = (q_count == CW'(FIFO_DEPTH));
   assign kbd_data = kbd_int ? mem[rd_ptr] : 8'h00;
`else
   logic [7:0] hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold <= 8'h00;
      end else if (push_ok) begin
         hold <= ps2_rx_data;
      end
   end

   assign q_full   = (q_count != '0);
   assign kbd_data = hold;
`endif

endmodule
